// File: rtl/dma_bus_master_pkg.sv
// Shared types and constants for the single-channel DMA bus master.
// Holds the FSM state encoding, bus qualifier constants and buffer word indices.
package dma_bus_master_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetchA,
      StFetchD,
      StReq,
      StBegin,
      StWdata,
      StWend,
      StRwait
   } state_e;

   localparam logic [3:0]  BE_ALL       = 4'hF;
   localparam logic [7:0]  BURST_SINGLE = 8'd0;

   // Word positions of a write job inside the ping-pong buffer half.
   localparam logic [31:0] POP_IDX_ADDR = 32'd0;
   localparam logic [31:0] POP_IDX_DATA = 32'd1;

endpackage

// File: rtl/dma_bus_master_if.sv
// Shared multiplexed address/data system bus plus arbiter request/grant.
// The master modport is the DMA side; the slave modport is the arbiter/slave side.
interface dma_bus_master_if;

   logic        request;
   logic        granted;
   logic [31:0] address_dataIN;
   logic        end_transactionIN;
   logic        data_validIN;
   logic        busyIN;
   logic        errorIN;
   logic [31:0] address_dataOUT;
   logic [3:0]  byte_enableOUT;
   logic [7:0]  busrt_sizeOUT;
   logic        read_n_writeOUT;
   logic        begin_transactionOUT;
   logic        end_transactionOUT;
   logic        data_validOUT;
   logic        busyOUT;

   modport master (
      output request,
      output address_dataOUT,
      output byte_enableOUT,
      output busrt_sizeOUT,
      output read_n_writeOUT,
      output begin_transactionOUT,
      output end_transactionOUT,
      output data_validOUT,
      output busyOUT,
      input  granted,
      input  address_dataIN,
      input  end_transactionIN,
      input  data_validIN,
      input  busyIN,
      input  errorIN
   );

   modport slave (
      input  request,
      input  address_dataOUT,
      input  byte_enableOUT,
      input  busrt_sizeOUT,
      input  read_n_writeOUT,
      input  begin_transactionOUT,
      input  end_transactionOUT,
      input  data_validOUT,
      input  busyOUT,
      output granted,
      output address_dataIN,
      output end_transactionIN,
      output data_validIN,
      output busyIN,
      output errorIN
   );

endinterface

// File: rtl/dma_bus_master.sv
// Single-channel DMA: single-word bus writes sourced from the ping-pong buffer and
// single-word bus reads pushed back into it. Outputs are decoded from state and bus inputs.
module dma_bus_master
   import dma_bus_master_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             dataReady,
   input  logic             readReady,
   input  logic [31:0]      address_to_read,
   output logic [31:0]      popAddress,
   input  logic [31:0]      popData,
   output logic [31:0]      pushAddress,
   output logic [31:0]      pushData,
   output logic             push,
   output logic             switch,
   dma_bus_master_if.master bus
);

   state_e      r_state;
   state_e      w_state_d;
   logic        r_wr_pend;
   logic        r_rd_pend;
   logic        r_is_read;
   logic [31:0] r_rd_addr;
   logic [31:0] r_dest;
   logic [31:0] r_data;
   logic [31:0] r_push_ptr;
   logic        w_wr_done;
   logic        w_rd_done;

   always_comb begin
      w_state_d                = r_state;
      w_wr_done                = 1'b0;
      w_rd_done                = 1'b0;
      popAddress               = POP_IDX_ADDR;
      pushAddress              = '0;
      pushData                 = '0;
      push                     = 1'b0;
      switch                   = 1'b0;
      bus.request              = 1'b0;
      bus.address_dataOUT      = '0;
      bus.byte_enableOUT       = '0;
      bus.busrt_sizeOUT        = '0;
      bus.read_n_writeOUT      = 1'b0;
      bus.begin_transactionOUT = 1'b0;
      bus.end_transactionOUT   = 1'b0;
      bus.data_validOUT        = 1'b0;
      bus.busyOUT              = 1'b0;

      unique case (r_state)
         StIdle: begin
            // Write job wins when both are pending; the read stays pending.
            if (r_wr_pend) begin
               w_state_d = StFetchA;
            end else if (r_rd_pend) begin
               w_state_d = StReq;
            end
         end
         StFetchA: begin
            popAddress = POP_IDX_DATA;
            w_state_d  = StFetchD;
         end
         StFetchD: begin
            w_state_d = StReq;
         end
         StReq: begin
            bus.request = 1'b1;
            if (bus.granted) begin
               w_state_d = StBegin;
            end
         end
         StBegin: begin
            bus.begin_transactionOUT = 1'b1;
            bus.address_dataOUT      = r_is_read ? r_rd_addr : r_dest;
            bus.read_n_writeOUT      = r_is_read;
            bus.byte_enableOUT       = BE_ALL;
            bus.busrt_sizeOUT        = BURST_SINGLE;
            if (bus.errorIN) begin
               w_wr_done = ~r_is_read;
               w_rd_done = r_is_read;
               w_state_d = StIdle;
            end else begin
               w_state_d = r_is_read ? StRwait : StWdata;
            end
         end
         StWdata: begin
            bus.data_validOUT   = 1'b1;
            bus.address_dataOUT = r_data;
            if (bus.errorIN) begin
               w_wr_done = 1'b1;
               w_state_d = StIdle;
            end else if (!bus.busyIN) begin
               w_state_d = StWend;
            end
         end
         StWend: begin
            bus.end_transactionOUT = 1'b1;
            w_wr_done              = 1'b1;
            w_state_d              = StIdle;
         end
         StRwait: begin
            if (bus.errorIN) begin
               w_rd_done = 1'b1;
               w_state_d = StIdle;
            end else begin
               if (bus.data_validIN) begin
                  push        = 1'b1;
                  pushData    = bus.address_dataIN;
                  pushAddress = r_push_ptr;
               end
               if (bus.end_transactionIN) begin
                  switch    = 1'b1;
                  w_rd_done = 1'b1;
                  w_state_d = StIdle;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_wr_pend  <= 1'b0;
         r_rd_pend  <= 1'b0;
         r_is_read  <= 1'b0;
         r_rd_addr  <= '0;
         r_dest     <= '0;
         r_data     <= '0;
         r_push_ptr <= '0;
      end else begin
         r_state <= w_state_d;

         // One-deep job flags: a pulse while already pending is dropped.
         if (w_wr_done) begin
            r_wr_pend <= 1'b0;
         end else if (dataReady) begin
            r_wr_pend <= 1'b1;
         end

         if (w_rd_done) begin
            r_rd_pend <= 1'b0;
         end else if (readReady && !r_rd_pend) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= address_to_read;
         end

         if (r_state == StIdle && (r_wr_pend || r_rd_pend)) begin
            r_is_read <= ~r_wr_pend;
         end

         // popData trails popAddress by one cycle: word 0 arrives in FETCH_A, word 1 in FETCH_D.
         if (r_state == StFetchA) begin
            r_dest <= popData;
         end
         if (r_state == StFetchD) begin
            r_data <= popData;
         end

         if (switch) begin
            r_push_ptr <= '0;
         end else if (push) begin
            r_push_ptr <= r_push_ptr + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: a reactive bus slave, a buffer model and an event monitor,
// compared against a job-level model of the expected bus and buffer traffic.
module tb_dma_bus_master;

   typedef enum int {ErrNone, ErrBegin, ErrWdata, ErrRwait} err_e;

   typedef struct {
      bit          do_wr;
      bit          do_rd;
      bit          dup;
      logic [31:0] dest;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] rdata;
      int          glat;
      int          busy;
      int          rlat;
      int          nwords;
      err_e        err;
      int          e_beg;
      int          e_wdv;
      int          e_end;
      int          e_push;
      int          e_sw;
      int          e_req;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        dataReady;
   logic        readReady;
   logic [31:0] address_to_read;
   logic [31:0] popAddress;
   logic [31:0] popData;
   logic [31:0] pushAddress;
   logic [31:0] pushData;
   logic        push;
   logic        sw;

   dma_bus_master_if bus_if ();

   dma_bus_master dut (
      .clock           (clock),
      .reset           (reset),
      .dataReady       (dataReady),
      .readReady       (readReady),
      .address_to_read (address_to_read),
      .popAddress      (popAddress),
      .popData         (popData),
      .pushAddress     (pushAddress),
      .pushData        (pushData),
      .push            (push),
      .switch          (sw),
      .bus             (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Buffer half with one-cycle read latency.
   logic [31:0] mem [2];
   always @(posedge clock) popData <= mem[popAddress[0]];

   // Reactive slave/arbiter configuration and state.
   int          cfg_glat, cfg_busy, cfg_rlat, cfg_nwords;
   err_e        cfg_err;
   logic [31:0] cfg_rdata;
   bit          err_used;
   int          req_cnt, wd_k, rk;
   bit          in_rwait;

   always @(negedge clock) begin
      bus_if.granted           = 1'b0;
      bus_if.busyIN            = 1'b0;
      bus_if.errorIN           = 1'b0;
      bus_if.data_validIN      = 1'b0;
      bus_if.end_transactionIN = 1'b0;
      bus_if.address_dataIN    = '0;
      if (!reset) begin
         req_cnt  = 0;
         in_rwait = 1'b0;
         wd_k     = 0;
      end else begin
         if (bus_if.request) begin
            if (req_cnt >= cfg_glat) begin
               bus_if.granted = 1'b1;
               req_cnt        = 0;
            end else begin
               req_cnt++;
            end
         end else begin
            req_cnt = 0;
         end
         if (in_rwait) begin
            if (rk >= cfg_rlat) begin
               if (cfg_err == ErrRwait && !err_used) begin
                  bus_if.errorIN = 1'b1;
                  err_used       = 1'b1;
                  in_rwait       = 1'b0;
               end else begin
                  bus_if.data_validIN   = 1'b1;
                  bus_if.address_dataIN = cfg_rdata + 32'(rk - cfg_rlat);
                  if (rk - cfg_rlat == cfg_nwords - 1) begin
                     bus_if.end_transactionIN = 1'b1;
                     in_rwait                 = 1'b0;
                  end
               end
            end
            rk++;
         end
         if (bus_if.begin_transactionOUT) begin
            wd_k = 0;
            if (cfg_err == ErrBegin && !err_used) begin
               bus_if.errorIN = 1'b1;
               err_used       = 1'b1;
            end else if (bus_if.read_n_writeOUT) begin
               in_rwait = 1'b1;
               rk       = 0;
            end
         end
         if (bus_if.data_validOUT) begin
            if (cfg_err == ErrWdata && !err_used) begin
               bus_if.errorIN = 1'b1;
               err_used       = 1'b1;
            end else begin
               bus_if.busyIN = (wd_k < cfg_busy);
            end
            wd_k++;
         end
      end
   end

   // Event monitor, sampled late in the low phase after the slave has reacted.
   logic [63:0] q_beg [$];
   logic [63:0] q_wdv [$];
   logic [63:0] q_push [$];
   int          n_end, n_sw, n_req, n_viol;

   always @(negedge clock) begin
      #3;
      if (reset) begin
         if (bus_if.begin_transactionOUT)
            q_beg.push_back({19'd0, bus_if.address_dataOUT, bus_if.read_n_writeOUT,
                             bus_if.byte_enableOUT, bus_if.busrt_sizeOUT});
         if (bus_if.data_validOUT) q_wdv.push_back({32'd0, bus_if.address_dataOUT});
         if (bus_if.end_transactionOUT) n_end++;
         if (push) q_push.push_back({pushAddress, pushData});
         if (sw) n_sw++;
         if (bus_if.request) n_req++;
         if (!(bus_if.begin_transactionOUT || bus_if.data_validOUT || bus_if.end_transactionOUT) &&
             (bus_if.address_dataOUT != 0 || bus_if.byte_enableOUT != 0 ||
              bus_if.busrt_sizeOUT != 0 || bus_if.read_n_writeOUT))
            n_viol++;
         if (bus_if.busyOUT) n_viol++;
      end
   end

   task automatic clr_mon();
      q_beg.delete();
      q_wdv.delete();
      q_push.delete();
      n_end  = 0;
      n_sw   = 0;
      n_req  = 0;
      n_viol = 0;
   endtask

   // Job-level expectation: write first (if any), then read; errors drop only their job.
   logic [63:0] e_beg [$];
   logic [63:0] e_wdv [$];
   logic [63:0] e_push [$];
   int          e_end, e_sw, e_req;

   task automatic model(input vec_t v);
      e_beg.delete();
      e_wdv.delete();
      e_push.delete();
      e_end = 0;
      e_sw  = 0;
      e_req = 0;
      if (v.do_wr) begin
         e_req += v.glat + 1;
         e_beg.push_back({19'd0, v.dest, 1'b0, 4'hF, 8'd0});
         if (v.err == ErrWdata) begin
            e_wdv.push_back({32'd0, v.wdata});
         end else if (v.err != ErrBegin) begin
            for (int i = 0; i <= v.busy; i++) e_wdv.push_back({32'd0, v.wdata});
            e_end++;
         end
      end
      if (v.do_rd) begin
         e_req += v.glat + 1;
         e_beg.push_back({19'd0, v.raddr, 1'b1, 4'hF, 8'd0});
         if (!(v.err == ErrRwait || (v.err == ErrBegin && !v.do_wr))) begin
            for (int i = 0; i < v.nwords; i++) e_push.push_back({32'(i), v.rdata + 32'(i)});
            e_sw++;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input bit use_tbl, input string tag);
      int bound;
      mem[0]     = v.dest;
      mem[1]     = v.wdata;
      cfg_glat   = v.glat;
      cfg_busy   = v.busy;
      cfg_rlat   = v.rlat;
      cfg_nwords = v.nwords;
      cfg_rdata  = v.rdata;
      cfg_err    = v.err;
      err_used   = 1'b0;
      @(negedge clock);
      clr_mon();
      dataReady       = v.do_wr;
      readReady       = v.do_rd;
      address_to_read = v.raddr;
      @(negedge clock);
      if (v.dup) begin
         address_to_read = ~v.raddr;
         @(negedge clock);
      end
      dataReady       = 1'b0;
      readReady       = 1'b0;
      address_to_read = '0;
      bound = 2 * (v.glat + 1) + v.busy + v.rlat + v.nwords + 30;
      repeat (bound) @(negedge clock);
      #4;
      model(v);
      chk($sformatf("%s.nbeg", tag), 64'(q_beg.size()), 64'(e_beg.size()));
      for (int i = 0; i < q_beg.size() && i < e_beg.size(); i++)
         chk($sformatf("%s.beg%0d", tag, i), q_beg[i], e_beg[i]);
      chk($sformatf("%s.nwdv", tag), 64'(q_wdv.size()), 64'(e_wdv.size()));
      for (int i = 0; i < q_wdv.size() && i < e_wdv.size(); i++)
         chk($sformatf("%s.wdv%0d", tag, i), q_wdv[i], e_wdv[i]);
      chk($sformatf("%s.nend", tag), 64'(n_end), 64'(e_end));
      chk($sformatf("%s.npush", tag), 64'(q_push.size()), 64'(e_push.size()));
      for (int i = 0; i < q_push.size() && i < e_push.size(); i++)
         chk($sformatf("%s.push%0d", tag, i), q_push[i], e_push[i]);
      chk($sformatf("%s.nsw", tag), 64'(n_sw), 64'(e_sw));
      chk($sformatf("%s.nreq", tag), 64'(n_req), 64'(e_req));
      chk($sformatf("%s.idle_bus", tag), 64'(n_viol), 64'd0);
      chk($sformatf("%s.req_low", tag), 64'(bus_if.request), 64'd0);
      if (use_tbl) begin
         chk($sformatf("%s.tbl_beg", tag), 64'(q_beg.size()), 64'(v.e_beg));
         chk($sformatf("%s.tbl_wdv", tag), 64'(q_wdv.size()), 64'(v.e_wdv));
         chk($sformatf("%s.tbl_end", tag), 64'(n_end), 64'(v.e_end));
         chk($sformatf("%s.tbl_push", tag), 64'(q_push.size()), 64'(v.e_push));
         chk($sformatf("%s.tbl_sw", tag), 64'(n_sw), 64'(v.e_sw));
         chk($sformatf("%s.tbl_req", tag), 64'(n_req), 64'(v.e_req));
      end
   endtask

   function automatic vec_t mk(bit w, bit r, bit d, logic [31:0] dest, logic [31:0] wdata,
                               logic [31:0] raddr, logic [31:0] rdata, int glat, int busy,
                               int rlat, int nw, err_e err, int eb, int ewd, int ee, int ep,
                               int es, int er);
      vec_t v;
      v.do_wr = w;     v.do_rd = r;     v.dup = d;
      v.dest  = dest;  v.wdata = wdata; v.raddr = raddr; v.rdata = rdata;
      v.glat  = glat;  v.busy  = busy;  v.rlat  = rlat;  v.nwords = nw;  v.err = err;
      v.e_beg = eb;    v.e_wdv = ewd;   v.e_end = ee;    v.e_push = ep;
      v.e_sw  = es;    v.e_req = er;
      return v;
   endfunction

   function automatic bit any_out();
      return |{popAddress, pushAddress, pushData, push, sw, bus_if.request,
               bus_if.address_dataOUT, bus_if.byte_enableOUT, bus_if.busrt_sizeOUT,
               bus_if.read_n_writeOUT, bus_if.begin_transactionOUT,
               bus_if.end_transactionOUT, bus_if.data_validOUT, bus_if.busyOUT};
   endfunction

   vec_t tbl [10];

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      bit   seen;
      reset           = 1'b0;
      dataReady       = 1'b0;
      readReady       = 1'b0;
      address_to_read = '0;
      mem[0]          = '0;
      mem[1]          = '0;
      cfg_glat        = 0;
      cfg_busy        = 0;
      cfg_rlat        = 0;
      cfg_nwords      = 1;
      cfg_rdata       = '0;
      cfg_err         = ErrNone;
      err_used        = 1'b0;
      clr_mon();

      //        w  r  d  dest          wdata         raddr         rdata
      //        glat busy rlat nw err        beg wdv end push sw req
      tbl[0] = mk(1, 0, 0, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0,        32'h0,
                  1, 5, 0, 1, ErrNone,  1, 6, 1, 0, 0, 2);
      tbl[1] = mk(0, 1, 0, 32'h0,        32'h0,        32'h0A0A_0A0A, 32'h1234_5678,
                  0, 0, 0, 1, ErrNone,  1, 0, 0, 1, 1, 1);
      tbl[2] = mk(1, 1, 0, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_3000, 32'hCAFE_F00D,
                  0, 1, 2, 1, ErrNone,  2, 2, 1, 1, 1, 2);
      tbl[3] = mk(0, 1, 0, 32'h0,        32'h0,        32'h0000_0040, 32'h7777_0000,
                  0, 0, 1, 1, ErrRwait, 1, 0, 0, 0, 0, 1);
      tbl[4] = mk(1, 0, 0, 32'h0000_4444, 32'h0BAD_F00D, 32'h0,        32'h0,
                  10, 0, 0, 1, ErrNone, 1, 1, 1, 0, 0, 11);
      tbl[5] = mk(1, 0, 0, 32'h0000_5550, 32'h1357_9BDF, 32'h0,        32'h0,
                  0, 2, 0, 1, ErrBegin, 1, 0, 0, 0, 0, 1);
      tbl[6] = mk(1, 0, 0, 32'h0000_6660, 32'h2468_ACE0, 32'h0,        32'h0,
                  0, 3, 0, 1, ErrWdata, 1, 1, 0, 0, 0, 1);
      tbl[7] = mk(0, 1, 0, 32'h0,        32'h0,        32'h0000_7000, 32'h0000_0100,
                  2, 0, 1, 3, ErrNone,  1, 0, 0, 3, 1, 3);
      tbl[8] = mk(1, 1, 0, 32'h0000_8000, 32'h8888_8888, 32'h0000_9000, 32'h9999_0000,
                  0, 0, 0, 1, ErrBegin, 2, 0, 0, 1, 1, 2);
      tbl[9] = mk(1, 1, 1, 32'h0000_A000, 32'hAAAA_5555, 32'h0000_B000, 32'hBBBB_0000,
                  1, 1, 0, 2, ErrNone,  2, 2, 1, 2, 1, 4);

      repeat (3) @(negedge clock);
      #4;
      chk("reset.outputs", 64'(any_out()), 64'd0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #4;
      chk("reset.idle_after", 64'(any_out()), 64'd0);

      foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Reset asserted in the middle of a stalled write data phase.
      cfg_glat = 0; cfg_busy = 30; cfg_rlat = 0; cfg_nwords = 1;
      cfg_err  = ErrNone; err_used = 1'b0;
      mem[0]   = 32'h0000_5000;
      mem[1]   = 32'h1111_2222;
      @(negedge clock);
      dataReady = 1'b1;
      @(negedge clock);
      dataReady = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         #4;
         seen = bus_if.data_validOUT;
      end
      chk("rst_mid.dv_seen", 64'(seen), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid.outputs", 64'(any_out()), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      clr_mon();
      repeat (20) @(negedge clock);
      #4;
      chk("rst_mid.no_req", 64'(n_req), 64'd0);
      chk("rst_mid.no_beg", 64'(q_beg.size()), 64'd0);
      run_vec(tbl[1], 1'b1, "rst_mid.read");

      for (int n = 0; n < 20; n++) begin
         int r;
         v.do_wr  = 1'($urandom_range(0, 1));
         v.do_rd  = v.do_wr ? 1'($urandom_range(0, 1)) : 1'b1;
         v.dup    = 1'($urandom_range(0, 1));
         v.dest   = $urandom;
         v.wdata  = $urandom;
         v.raddr  = $urandom;
         v.rdata  = $urandom;
         v.glat   = int'($urandom_range(0, 4));
         v.busy   = int'($urandom_range(0, 4));
         v.rlat   = int'($urandom_range(0, 3));
         v.nwords = int'($urandom_range(1, 3));
         r        = int'($urandom_range(0, 7));
         v.err    = (r == 0) ? ErrBegin :
                    (r == 1 && v.do_wr) ? ErrWdata :
                    (r == 2 && v.do_rd) ? ErrRwait : ErrNone;
         v.e_beg = 0; v.e_wdv = 0; v.e_end = 0; v.e_push = 0; v.e_sw = 0; v.e_req = 0;
         run_vec(v, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- Single-channel DMA bridging a ping-pong word buffer and the shared 32-bit multiplexed address/data system bus.
- Write path: on dataReady, pops a destination address and one data word from the buffer, then performs a single-word bus write.
- Read path: on readReady, performs a single-word bus read from address_to_read and pushes the returned word into the buffer.
- Acts as a bus master only; obtains the bus through the request/granted arbiter.

Parameters:
- None; all widths are fixed.

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- dataReady  in  1  pulse: buffer holds a write job (word 0 = destination address, word 1 = data)
- readReady  in  1  pulse: start a read from address_to_read
- address_to_read  in  32  read address, sampled when readReady=1
- popAddress  out  32  buffer read index
- popData  in  32  buffer read data, valid one cycle after popAddress
- pushAddress  out  32  buffer write index
- pushData  out  32  buffer write data
- push  out  1  buffer write strobe
- switch  out  1  one-cycle pulse that swaps the ping-pong halves
- request  out  1  bus request to arbiter
- granted  in  1  bus grant (may be a single-cycle pulse)
- address_dataIN  in  32  bus address/data from slave
- end_transactionIN  in  1  slave end of transaction
- data_validIN  in  1  slave read data valid
- busyIN  in  1  slave wait/stall
- errorIN  in  1  slave error
- address_dataOUT  out  32  bus address (begin cycle) or write data
- byte_enableOUT  out  4  byte enables
- busrt_sizeOUT  out  8  burst length minus 1
- read_n_writeOUT  out  1  1=read, 0=write
- begin_transactionOUT  out  1  begin strobe
- end_transactionOUT  out  1  master end strobe
- data_validOUT  out  1  write data valid
- busyOUT  out  1  master stall; tied 0

Behaviour:
- Reset (reset=0): every output 0; state IDLE; pending flags and push pointer cleared.
- Bus outputs are 0 whenever the DMA is not in BEGIN, WDATA or WEND.
- Job capture:
  - dataReady or readReady sets its pending flag (one-deep); a repeated pulse while pending is ignored.
  - readReady latches address_to_read.
  - In IDLE the write job has priority if both are pending (simultaneous pulses included); the read is serviced afterwards.
- States: IDLE, FETCH_A, FETCH_D, REQ, BEGIN, WDATA, WEND, RWAIT.
- Write sequence:
  - IDLE->FETCH_A: popAddress=0.
  - FETCH_A: popAddress=1. The word returned for index 0 is captured as the destination address at the end of FETCH_A, or first thing in FETCH_D; choose one and keep popAddress/popData alignment with the one-cycle popData latency.
  - FETCH_D: capture popData as the data word; go to REQ.
  - REQ: request=1 until granted is sampled 1; then BEGIN.
  - BEGIN (1 cycle): begin_transactionOUT=1, address_dataOUT=destination, read_n_writeOUT=0, byte_enableOUT=4'hF, busrt_sizeOUT=0.
  - WDATA: data_validOUT=1, address_dataOUT=data word; held unchanged while busyIN=1. Exit to WEND on the first cycle with busyIN=0.
  - WEND (1 cycle): end_transactionOUT=1; then IDLE; write pending flag cleared.
- Read sequence:
  - IDLE->REQ (read job), then BEGIN with address_dataOUT=latched address, read_n_writeOUT=1, byte_enableOUT=4'hF, busrt_sizeOUT=0.
  - Then RWAIT.
  - RWAIT: on data_validIN=1, push=1 for one cycle, pushData=address_dataIN, pushAddress=push pointer; pointer increments.
  - On end_transactionIN=1 (same cycle as data_validIN allowed): switch=1 for one cycle, push pointer reset to 0, then IDLE.
- Error: errorIN=1 in BEGIN, WDATA or RWAIT aborts to IDLE with no push and no switch; the job is dropped.
- request drops in the cycle after granted is sampled.
- The DMA does not assert request again until it returns to IDLE.

Decomposition:
- Shared package holds:
  - the state enum
  - bus constants: BE_ALL=4'hF, BURST_SINGLE=8'd0
  - buffer index constants: POP_IDX_ADDR=0, POP_IDX_DATA=1
- Flat module; no sub-module is natural.

Test Plan:
- Reset: assert reset=0 mid-transfer -> all outputs 0 immediately; IDLE after release.
- Write: buffer word0=0x00001000, word1=0xA5A5A5A5, pulse dataReady, grant 1 cycle, busyIN=1 for 5 cycles -> begin with address_dataOUT=0x00001000, read_n_writeOUT=0, byte_enableOUT=F; data_validOUT with 0xA5A5A5A5 held through busy; then a 1-cycle end_transactionOUT.
- Read: readReady with address_to_read=0x0A0A0A0A, grant, slave returns 0x12345678 with data_validIN=end_transactionIN=1 -> begin with address 0x0A0A0A0A, read_n_writeOUT=1; push=1, pushData=0x12345678, pushAddress=0; switch pulse.
- Priority: dataReady and readReady in the same cycle -> write completes first, then the read runs with no lost job.
- Error: errorIN=1 during RWAIT -> no push, no switch, IDLE, request=0.
- Grant latency: granted withheld 10 cycles -> request held high, no bus strobes until granted.
